// File: rtl/sum_of_squares.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sum_of_squares
//
// Streaming sum-of-squares accumulator feeding the pipelined integer
// square-root unit (vector-magnitude path). Signed elements arrive one per
// cycle, each is squared (stage 1) and accumulated (stage 2). On the last
// element of a vector a single 32-bit unsigned sum is emitted with a
// one-cycle valid pulse.
//
// Handshake: valid-only streaming with no backpressure. Every cycle with
// data_valid high is consumed. data_last is only meaningful together with
// data_valid. sum_valid is a single-cycle pulse; sum_out, sum_sat and
// sum_overrun are qualified by it and hold their last value otherwise.
//
// Parameters:
//   DATA_W   signed element width (<= 16 so a square fits in 32 bits)
//   MAX_LEN  maximum elements per vector (>= 1); longer vectors are
//            force-terminated and flagged with sum_overrun
//
// Ports:
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   data_in      in   DATA_W signed element
//   data_valid   in   element present this cycle
//   data_last    in   final element of the vector
//   sum_out      out  32-bit unsigned sum of squares
//   sum_valid    out  one-cycle result pulse
//   sum_sat      out  accumulation overflowed 32 bits
//   sum_overrun  out  vector force-terminated at MAX_LEN
//
// Build option:
//   SOS_SATURATE_EN  defined   -> accumulator and result clamp to
//                                 32'hFFFF_FFFF on overflow (sticky)
//                    undefined -> accumulator wraps modulo 2^32
//   sum_sat reports the overflow in both builds.
// ---------------------------------------------------------------------------
module sum_of_squares #(
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    input  logic                     data_last,
    output logic [31:0]              sum_out,
    output logic                     sum_valid,
    output logic                     sum_sat,
    output logic                     sum_overrun
);

    // A 1-element limit still needs a 1-bit counter (it simply stays at 0).
    localparam int              CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_LEN - 1);

    // Stage 1 state
    logic [31:0]      sq_q,       sq_d;
    logic             sq_valid_q, sq_valid_d;
    logic             sq_last_q,  sq_last_d;
    logic             sq_over_q,  sq_over_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Stage 2 state
    logic [31:0]      acc_q,         acc_d;
    logic             sat_q,         sat_d;
    logic [31:0]      sum_out_q,     sum_out_d;
    logic             sum_valid_q,   sum_valid_d;
    logic             sum_sat_q,     sum_sat_d;
    logic             sum_overrun_q, sum_overrun_d;

    // Square in 32-bit signed arithmetic; with DATA_W <= 16 the largest
    // square is 2^30, so the product is always non-negative and exact.
    logic signed [31:0] din_ext;
    logic signed [31:0] sq_full;
    logic               at_top;
    logic               elem_last;

    assign din_ext   = {{(32-DATA_W){data_in[DATA_W-1]}}, data_in};
    assign sq_full   = din_ext * din_ext;
    assign at_top    = (cnt_q == CNT_TOP);
    assign elem_last = data_last | at_top;

    always_comb begin
        sq_d       = sq_q;
        sq_last_d  = sq_last_q;
        sq_over_d  = sq_over_q;
        cnt_d      = cnt_q;
        sq_valid_d = data_valid;
        if (data_valid) begin
            sq_d      = unsigned'(sq_full);
            sq_last_d = elem_last;
            // Overrun only when the limit, not the producer, ended the vector.
            sq_over_d = at_top & ~data_last;
            cnt_d     = elem_last ? '0 : cnt_q + 1'b1;
        end
    end

    // 33-bit add so the carry out is the overflow indication.
    logic [32:0] acc_sum;
    logic        ovf;
    logic [31:0] acc_res;

    assign acc_sum = {1'b0, acc_q} + {1'b0, sq_q};
    assign ovf     = acc_sum[32];

`ifdef SOS_SATURATE_EN
    // Once clamped, further adds either overflow again or add zero, so the
    // clamp stays in place until the vector ends.
    assign acc_res = ovf ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
    assign acc_res = acc_sum[31:0];
`endif

    always_comb begin
        acc_d         = acc_q;
        sat_d         = sat_q;
        sum_out_d     = sum_out_q;
        sum_sat_d     = sum_sat_q;
        sum_overrun_d = sum_overrun_q;
        sum_valid_d   = 1'b0;
        if (sq_valid_q) begin
            if (!sq_last_q) begin
                acc_d = acc_res;
                sat_d = sat_q | ovf;
            end else begin
                sum_out_d     = acc_res;
                sum_sat_d     = sat_q | ovf;
                sum_overrun_d = sq_over_q;
                sum_valid_d   = 1'b1;
                // Next element starts a fresh vector with no bubble.
                acc_d         = '0;
                sat_d         = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sq_q          <= '0;
            sq_valid_q    <= 1'b0;
            sq_last_q     <= 1'b0;
            sq_over_q     <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            sum_out_q     <= '0;
            sum_valid_q   <= 1'b0;
            sum_sat_q     <= 1'b0;
            sum_overrun_q <= 1'b0;
        end else begin
            sq_q          <= sq_d;
            sq_valid_q    <= sq_valid_d;
            sq_last_q     <= sq_last_d;
            sq_over_q     <= sq_over_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            sum_out_q     <= sum_out_d;
            sum_valid_q   <= sum_valid_d;
            sum_sat_q     <= sum_sat_d;
            sum_overrun_q <= sum_overrun_d;
        end
    end

    assign sum_out     = sum_out_q;
    assign sum_valid   = sum_valid_q;
    assign sum_sat     = sum_sat_q;
    assign sum_overrun = sum_overrun_q;

endmodule

// File: tb/tb_sum_of_squares.sv
`timescale 1ns/1ps
module tb_sum_of_squares;

    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 4;

`ifdef SOS_SATURATE_EN
    localparam logic [31:0] OVF_SUM = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_SUM = 32'h0000_0000;
`endif

    // ---------------- clock / reset ----------------
    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic signed [DATA_W-1:0] data_in = '0;
    logic                     data_valid = 1'b0;
    logic                     data_last = 1'b0;
    logic [31:0]              sum_out;
    logic                     sum_valid;
    logic                     sum_sat;
    logic                     sum_overrun;

    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    sum_of_squares #(
        .DATA_W (DATA_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .sum_sat    (sum_sat),
        .sum_overrun(sum_overrun)
    );

    // ---------------- scoreboard ----------------
    // entry: {expected pulse cycle[31:0], overrun, sat, sum[31:0]}
    logic [65:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int issue_cyc = 0;
    logic [31:0] hold_sum  = '0;
    logic        hold_sat  = 1'b0;
    logic        hold_over = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic elem(input int v, input logic lst);
        @(negedge clock);
        data_in    = DATA_W'(v);
        data_valid = 1'b1;
        data_last  = lst;
        // Sampled on the coming edge; result registered one edge later.
        issue_cyc  = cyc_cnt + 2;
    endtask

    task automatic idle(input logic lst);
        @(negedge clock);
        data_in    = DATA_W'($urandom_range(0, 65535));
        data_valid = 1'b0;
        data_last  = lst;
    endtask

    task automatic expect_sum(input logic [31:0] s, input logic sat, input logic over);
        exp_q.push_back({32'(issue_cyc), over, sat, s});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic [65:0] e;
        if (!reset_n) begin
            check("rst_sum_valid", 32'(sum_valid), 32'd0);
            check("rst_sum_out", sum_out, 32'd0);
            check("rst_sum_sat", 32'(sum_sat), 32'd0);
            check("rst_sum_overrun", 32'(sum_overrun), 32'd0);
            hold_sum  = '0;
            hold_sat  = 1'b0;
            hold_over = 1'b0;
        end else if (sum_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got sum_out=%0h with no result expected (t=%0t)", sum_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("sum_out", sum_out, e[31:0]);
                check("sum_sat", 32'(sum_sat), 32'(e[32]));
                check("sum_overrun", 32'(sum_overrun), 32'(e[33]));
                check("latency_cycle", 32'(cyc_cnt), e[65:34]);
                hold_sum  = e[31:0];
                hold_sat  = e[32];
                hold_over = e[33];
            end
        end else begin
            check("hold_sum_out", sum_out, hold_sum);
            check("hold_sum_sat", 32'(sum_sat), 32'(hold_sat));
            check("hold_sum_overrun", 32'(sum_overrun), 32'(hold_over));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // single-element vector: 5^2
        elem(5, 1'b1);      expect_sum(32'd25, 1'b0, 1'b0);
        repeat (4) idle(1'b0);

        // back-to-back vectors: 9+16, 36+64
        elem(3, 1'b0);
        elem(4, 1'b1);      expect_sum(32'd25, 1'b0, 1'b0);
        elem(-6, 1'b0);
        elem(8, 1'b1);      expect_sum(32'd100, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // mixed signs: 1 + 90000 + 40000
        elem(-1, 1'b0);
        elem(300, 1'b0);
        elem(-200, 1'b1);   expect_sum(32'd130001, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // overflow: 4 * 2^30 = 2^32
        elem(-32768, 1'b0);
        elem(-32768, 1'b0);
        elem(-32768, 1'b0);
        elem(-32768, 1'b1); expect_sum(OVF_SUM, 1'b1, 1'b0);
        repeat (3) idle(1'b0);

        // next vector after overflow must start clean
        elem(2, 1'b1);      expect_sum(32'd4, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // force termination at MAX_LEN=4
        elem(1, 1'b0);
        elem(1, 1'b0);
        elem(1, 1'b0);
        elem(1, 1'b0);      expect_sum(32'd4, 1'b0, 1'b1);
        elem(1, 1'b0);
        repeat (2) idle(1'b0);
        elem(0, 1'b1);      expect_sum(32'd1, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // reset mid-vector discards the partial sum
        elem(10, 1'b0);
        elem(10, 1'b0);
        @(negedge clock);
        data_valid = 1'b0;
        data_last  = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        elem(2, 1'b1);      expect_sum(32'd4, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // gaps and a stray last on an idle cycle
        elem(1, 1'b0);
        idle(1'b0);
        elem(2, 1'b0);
        idle(1'b1);
        idle(1'b0);
        elem(2, 1'b1);      expect_sum(32'd9, 1'b0, 1'b0);
        idle(1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
